// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive deserialiser.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int unsigned BIT_CNT_W     = 4;
  localparam int unsigned MAX_DATA_BITS = 9;

  // Total bits on the wire for one frame, start bit included.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  // Centre tick of a bit period.
  function automatic int unsigned mid_tick(input int unsigned oversample);
    return oversample / 2;
  endfunction

  // True when the received parity bit disagrees with the selected sense.
  function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] data,
                                           input logic                     par_bit,
                                           input logic                     odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit tick counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic baud_clk,
  input  logic reset_n,
  input  logic data_tx,
  input  logic run,
  output logic line_sync,
  output logic sample_valid_c,
  output logic bit_value_c,
  output logic bit_end_c
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID    = mid_tick(OVERSAMPLE);

  logic              sync1_q;
  logic              sync2_q;
  logic [TICK_W-1:0] tick_q;
  logic              s_early_q;
  logic              s_mid_q;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_tx;
      sync2_q <= sync1_q;
    end
  end

  // Tick counter: held at 0 while idle, wraps on every bit boundary.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
    end else if (!run || bit_end_c) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

  // Capture the two samples that precede the decision tick.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_early_q <= 1'b1;
      s_mid_q   <= 1'b1;
    end else begin
      if (tick_q == TICK_W'(MID - 1)) s_early_q <= sync2_q;
      if (tick_q == TICK_W'(MID))     s_mid_q   <= sync2_q;
    end
  end

  // Majority vote with the third sample taken live at MID+1.
  always_comb begin
    sample_valid_c = run && (tick_q == TICK_W'(MID + 1));
    bit_value_c    = (s_early_q & s_mid_q) | (s_early_q & sync2_q) | (s_mid_q & sync2_q);
    bit_end_c      = run && (tick_q == TICK_W'(OVERSAMPLE - 1));
  end

  assign line_sync = sync2_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Parametrised UART receiver: frame FSM on top of the oversampling sampler.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 data_tx,
  output logic                 active_flag,
  output logic                 recieved_flag,
  output logic [DATA_BITS-1:0] data_parll,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect
);

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   zero_q, zero_d;
  logic                   active_q, active_d;
  logic                   rx_flag_q, rx_flag_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   bd_q, bd_d;

  logic run_c;
  logic line_sync;
  logic sample_valid_c;
  logic bit_value_c;
  logic bit_end_c;

  assign run_c = (state_q == START) || (state_q == DATA) ||
                 (state_q == PARITY) || (state_q == STOP);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .baud_clk       (baud_clk),
    .reset_n        (reset_n),
    .data_tx        (data_tx),
    .run            (run_c),
    .line_sync      (line_sync),
    .sample_valid_c (sample_valid_c),
    .bit_value_c    (bit_value_c),
    .bit_end_c      (bit_end_c)
  );

  // State, frame accumulators and registered outputs.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      zero_q    <= 1'b0;
      active_q  <= 1'b0;
      rx_flag_q <= 1'b0;
      data_q    <= '0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      bd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      zero_q    <= zero_d;
      active_q  <= active_d;
      rx_flag_q <= rx_flag_d;
      data_q    <= data_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      bd_q      <= bd_d;
    end
  end

  // Next-state logic; the frame commits on the last stop-bit decision.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    zero_d    = zero_q;
    rx_flag_d = 1'b0;
    data_d    = data_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    bd_d      = bd_q;

    case (state_q)
      IDLE: begin
        if (!line_sync) begin
          state_d   = START;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          zero_d    = 1'b1;
        end
      end
      START: begin
        if (sample_valid_c && bit_value_c) begin
          state_d = IDLE;
        end else if (bit_end_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_valid_c) begin
          shift_d = {bit_value_c, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~bit_value_c;
        end
        if (bit_end_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (sample_valid_c) begin
          par_err_d = parity_mismatch(MAX_DATA_BITS'(shift_q), bit_value_c, 1'(PARITY_ODD));
          zero_d    = zero_q & ~bit_value_c;
        end
        if (bit_end_c) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_valid_c) begin
          frm_err_d = frm_err_q | ~bit_value_c;
          zero_d    = zero_q & ~bit_value_c;
          if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
            rx_flag_d = 1'b1;
            data_d    = shift_q;
            pe_d      = par_err_q;
            fe_d      = frm_err_d;
            bd_d      = zero_d;
            state_d   = zero_d ? BREAK : IDLE;
          end
        end else if (bit_end_c) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
      BREAK: begin
        if (line_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d == START) || (state_d == DATA) ||
               (state_d == PARITY) || (state_d == STOP);
  end

  assign active_flag   = active_q;
  assign recieved_flag = rx_flag_q;
  assign data_parll    = data_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;
  assign break_detect  = bd_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and randomised frames against a frame-level reference model.
module tb_uart_rx_deserializer;

  logic baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  logic       reset_n_a, reset_n_b, data_a, data_b;
  logic       act_a, rx_a, pe_a, fe_a, bd_a;
  logic [7:0] dp_a;
  logic       act_b, rx_b, pe_b, fe_b, bd_b;
  logic [6:0] dp_b;

  uart_rx_deserializer u_dut_a (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n_a),
    .data_tx       (data_a),
    .active_flag   (act_a),
    .recieved_flag (rx_a),
    .data_parll    (dp_a),
    .parity_error  (pe_a),
    .framing_error (fe_a),
    .break_detect  (bd_a)
  );

  uart_rx_deserializer #(
    .DATA_BITS  (7),
    .OVERSAMPLE (8),
    .PARITY_EN  (1),
    .PARITY_ODD (1),
    .STOP_BITS  (2)
  ) u_dut_b (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n_b),
    .data_tx       (data_b),
    .active_flag   (act_b),
    .recieved_flag (rx_b),
    .data_parll    (dp_b),
    .parity_error  (pe_b),
    .framing_error (fe_b),
    .break_detect  (bd_b)
  );

  typedef struct packed {
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic        bd;
    logic [31:0] cyc;
  } rec_t;

  int   cyc = 0;
  rec_t q_a[$];
  rec_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Record every completed frame with the cycle it was flagged.
  always @(negedge baud_clk) begin
    if (rx_a) q_a.push_back('{data: 9'(dp_a), pe: pe_a, fe: fe_a, bd: bd_a, cyc: 32'(cyc)});
    if (rx_b) q_b.push_back('{data: 9'(dp_b), pe: pe_b, fe: fe_b, bd: bd_b, cyc: 32'(cyc)});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame-level model: even/odd ones count, any low stop bit, all-zero frame.
  function automatic rec_t model_a(input logic [7:0] d, input logic p, input logic s);
    rec_t r;
    r.data = 9'(d);
    r.pe   = (($countones(d) + int'(p)) % 2) != 0;
    r.fe   = !s;
    r.bd   = (d == 8'd0) && !p && !s;
    r.cyc  = '0;
    return r;
  endfunction

  function automatic rec_t model_b(input logic [6:0] d, input logic p, input logic s0, input logic s1);
    rec_t r;
    r.data = 9'(d);
    r.pe   = (($countones(d) + int'(p)) % 2) != 1;
    r.fe   = !(s0 && s1);
    r.bd   = (d == 7'd0) && !p && !s0 && !s1;
    r.cyc  = '0;
    return r;
  endfunction

  task automatic line_a(input logic v, input int ticks);
    data_a = v;
    repeat (ticks) @(negedge baud_clk);
  endtask

  task automatic line_b(input logic v, input int ticks);
    data_b = v;
    repeat (ticks) @(negedge baud_clk);
  endtask

  task automatic send_a(input logic [7:0] d, input logic p, input logic s, output logic [31:0] sc);
    sc = 32'(cyc + 1);
    line_a(1'b0, 16);
    for (int i = 0; i < 8; i++) line_a(d[i], 16);
    line_a(p, 16);
    line_a(s, 16);
  endtask

  task automatic send_b(input logic [6:0] d, input logic p, input logic s0, input logic s1);
    line_b(1'b0, 8);
    for (int i = 0; i < 7; i++) line_b(d[i], 8);
    line_b(p, 8);
    line_b(s0, 8);
    line_b(s1, 8);
  endtask

  task automatic pop_a(input string tag, input rec_t e);
    rec_t r;
    chk({tag, "_seen"}, 32'(q_a.size() != 0), 32'd1);
    if (q_a.size() != 0) begin
      r = q_a.pop_front();
      chk({tag, "_data"}, 32'(r.data), 32'(e.data));
      chk({tag, "_perr"}, 32'(r.pe), 32'(e.pe));
      chk({tag, "_ferr"}, 32'(r.fe), 32'(e.fe));
      chk({tag, "_brk"},  32'(r.bd), 32'(e.bd));
    end
  endtask

  task automatic pop_b(input string tag, input rec_t e);
    rec_t r;
    chk({tag, "_seen"}, 32'(q_b.size() != 0), 32'd1);
    if (q_b.size() != 0) begin
      r = q_b.pop_front();
      chk({tag, "_data"}, 32'(r.data), 32'(e.data));
      chk({tag, "_perr"}, 32'(r.pe), 32'(e.pe));
      chk({tag, "_ferr"}, 32'(r.fe), 32'(e.fe));
      chk({tag, "_brk"},  32'(r.bd), 32'(e.bd));
    end
  endtask

  // Send one frame on A, idle two bits, expect exactly one matching record.
  task automatic frame_a(input string tag, input logic [7:0] d, input logic p, input logic s);
    logic [31:0] sc;
    send_a(d, p, s, sc);
    line_a(1'b1, 32);
    chk({tag, "_count"}, 32'(q_a.size()), 32'd1);
    pop_a(tag, model_a(d, p, s));
  endtask

  initial begin
    logic [31:0] sc;
    logic [31:0] lat;
    logic        seen;
    logic [7:0]  rd;
    logic [6:0]  rdb;
    logic        rp, rs, rs1;

    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    data_a    = 1'b1;
    data_b    = 1'b1;
    repeat (3) @(negedge baud_clk);
    chk("rst_a_act",  32'(act_a), 32'd0);
    chk("rst_a_rx",   32'(rx_a),  32'd0);
    chk("rst_a_data", 32'(dp_a),  32'd0);
    chk("rst_a_flags", 32'({pe_a, fe_a, bd_a}), 32'd0);
    chk("rst_b_act",  32'(act_b), 32'd0);
    chk("rst_b_data", 32'(dp_b),  32'd0);
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    line_a(1'b1, 8);

    // 0xA5, even parity correct, checked for first-frame latency.
    send_a(8'hA5, 1'b0, 1'b1, sc);
    line_a(1'b1, 32);
    lat = (q_a.size() != 0) ? q_a[0].cyc - sc : 32'hFFFF_FFFF;
    chk("a5_latency", lat, 32'd172);
    chk("a5_count", 32'(q_a.size()), 32'd1);
    pop_a("a5", model_a(8'hA5, 1'b0, 1'b1));

    // Wrong parity, then a clean frame clears the error.
    frame_a("a_3c_badpar", 8'h3C, 1'b1, 1'b1);
    frame_a("a_00_good", 8'h00, 1'b0, 1'b1);

    // Stop bit low, then the same word cleanly.
    frame_a("a_81_frm", 8'h81, 1'b0, 1'b0);
    frame_a("a_81_clean", 8'h81, 1'b0, 1'b1);

    // Four-tick glitch on an idle line must be rejected.
    seen   = 1'b0;
    data_a = 1'b0;
    repeat (4) begin
      @(negedge baud_clk);
      if (act_a) seen = 1'b1;
    end
    data_a = 1'b1;
    repeat (10) begin
      @(negedge baud_clk);
      if (act_a) seen = 1'b1;
    end
    chk("glitch_active_seen", 32'(seen), 32'd1);
    chk("glitch_active_drop", 32'(act_a), 32'd0);
    line_a(1'b1, 32);
    chk("glitch_no_frame", 32'(q_a.size()), 32'd0);
    chk("glitch_data_hold", 32'(dp_a), 32'h81);
    chk("glitch_ferr_hold", 32'(fe_a), 32'd0);

    // Line held low for 20 bit times: one break frame, then silence.
    line_a(1'b0, 320);
    chk("break_active", 32'(act_a), 32'd0);
    chk("break_count", 32'(q_a.size()), 32'd1);
    pop_a("break", model_a(8'h00, 1'b0, 1'b0));
    line_a(1'b1, 32);
    chk("break_no_more", 32'(q_a.size()), 32'd0);
    frame_a("a_55_after_break", 8'h55, 1'b0, 1'b1);

    // Random frames on the default configuration.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom % 4) != 0;
      frame_a("a_rand", rd, rp, rs);
    end

    // Narrow configuration: back-to-back frames with no idle gap.
    line_b(1'b1, 8);
    send_b(7'h7F, 1'b0, 1'b1, 1'b1);
    send_b(7'h01, 1'b0, 1'b1, 1'b1);
    line_b(1'b1, 16);
    chk("b2b_count", 32'(q_b.size()), 32'd2);
    pop_b("b2b_7f", model_b(7'h7F, 1'b0, 1'b1, 1'b1));
    pop_b("b2b_01", model_b(7'h01, 1'b0, 1'b1, 1'b1));

    // Reset in the middle of a third frame's data bits.
    line_b(1'b0, 8);
    line_b(1'b1, 8);
    line_b(1'b1, 8);
    line_b(1'b0, 4);
    chk("b_mid_active", 32'(act_b), 32'd1);
    reset_n_b = 1'b0;
    #1;
    chk("b_rst_active", 32'(act_b), 32'd0);
    chk("b_rst_data",   32'(dp_b),  32'd0);
    chk("b_rst_flags",  32'({rx_b, pe_b, fe_b, bd_b}), 32'd0);
    data_b = 1'b1;
    repeat (3) @(negedge baud_clk);
    reset_n_b = 1'b1;
    line_b(1'b1, 100);
    chk("b_rst_no_frame", 32'(q_b.size()), 32'd0);

    // Random frames on the narrow configuration.
    for (int i = 0; i < 6; i++) begin
      rdb = 7'($urandom);
      rp  = 1'($urandom);
      rs  = ($urandom % 4) != 0;
      rs1 = ($urandom % 4) != 0;
      send_b(rdb, rp, rs, rs1);
      line_b(1'b1, 16);
      chk("b_rand_count", 32'(q_b.size()), 32'd1);
      pop_b("b_rand", model_b(rdb, rp, rs, rs1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
